// File: rtl/data_ram_resp.sv
// Data-memory responder for the MEM-stage load/store port: one request at a time,
// WAIT_CYCLES wait states, one-cycle ready pulse. Define DATA_RAM_ERR_EN to add ram_err_o.
module data_ram_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ram_ce_i,
    input  logic        ram_we_i,
    input  logic [3:0]  ram_sel_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
`ifdef DATA_RAM_ERR_EN
    output logic        ram_err_o,
`endif
    output logic        ram_ready_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_o_q, err_o_d;

    logic              capture, commit;
    logic              addr_err;
    logic              req_we;
    logic [3:0]        req_sel;
    logic [ADDR_W-1:0] req_idx;
    logic [31:0]       req_wdata;
    logic              req_err;

    logic [31:0]       mem [2**ADDR_W];

`ifdef DATA_RAM_ERR_EN
    assign addr_err  = |ram_addr_i[31:ADDR_W+2];
    assign ram_err_o = err_o_q;
    logic unused_bits;
    assign unused_bits = ^ram_addr_i[1:0];
`else
    assign addr_err = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{ram_addr_i[31:ADDR_W+2], ram_addr_i[1:0], err_o_q};
`endif

    // With zero wait states the commit happens on the capture edge, so it must use the live inputs.
    assign req_we    = capture ? ram_we_i                  : we_q;
    assign req_sel   = capture ? ram_sel_i                 : sel_q;
    assign req_idx   = capture ? ram_addr_i[ADDR_W+1:2]    : idx_q;
    assign req_wdata = capture ? ram_data_i                : wdata_q;
    assign req_err   = capture ? addr_err                  : err_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ram_ce_i) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = WAIT_LD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d = commit;
        err_o_d = commit & req_err;
        rdata_d = (commit && !req_we && !req_err) ? mem[req_idx] : 32'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_o_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_o_q <= err_o_d;
            if (capture) begin
                we_q    <= ram_we_i;
                sel_q   <= ram_sel_i;
                idx_q   <= ram_addr_i[ADDR_W+1:2];
                wdata_q <= ram_data_i;
                err_q   <= addr_err;
            end
        end
    end

    // NOTE: the array has no reset; it maps onto plain RAM and holds its contents across reset.
    always_ff @(posedge clk) begin
        if (commit && req_we && !req_err && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b]) begin
                    mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ram_data_o  = rdata_q;
    assign ram_ready_o = ready_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: a 2-wait-state instance and a 0-wait-state instance,
// compared every cycle against a transaction-level model of expected responses.
module tb_data_ram_resp;

    localparam int ADDR_W = 10;
    localparam int W0     = 2;
    localparam int W1     = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce   [2];
    logic        we   [2];
    logic [3:0]  sel  [2];
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [31:0] dout [2];
    logic        rdy  [2];
`ifdef DATA_RAM_ERR_EN
    logic        err  [2];
`endif

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    // Expected responses keyed by dut*1_000_000 + cycle: {err, data}; model memory keyed by dut*4096 + word.
    logic [32:0] exp_resp [int];
    logic [31:0] mm       [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_ram_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .ram_ce_i   (ce[0]),
        .ram_we_i   (we[0]),
        .ram_sel_i  (sel[0]),
        .ram_addr_i (addr[0]),
        .ram_data_i (wdat[0]),
        .ram_data_o (dout[0]),
`ifdef DATA_RAM_ERR_EN
        .ram_err_o  (err[0]),
`endif
        .ram_ready_o(rdy[0])
    );

    data_ram_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .ram_ce_i   (ce[1]),
        .ram_we_i   (we[1]),
        .ram_sel_i  (sel[1]),
        .ram_addr_i (addr[1]),
        .ram_data_i (wdat[1]),
        .ram_data_o (dout[1]),
`ifdef DATA_RAM_ERR_EN
        .ram_err_o  (err[1]),
`endif
        .ram_ready_o(rdy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    // Per-cycle compare of both instances against the expected-response map.
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            for (int d = 0; d < 2; d++) begin
                int          k;
                bit          hit;
                logic [32:0] e;
                k   = d * 1000000 + cyc;
                hit = exp_resp.exists(k);
                e   = 33'd0;
                if (hit) e = exp_resp[k];
                check($sformatf("ready%0d@%0d", d, cyc), {31'd0, rdy[d]}, {31'd0, hit});
                check($sformatf("data%0d@%0d", d, cyc), dout[d], e[31:0]);
`ifdef DATA_RAM_ERR_EN
                check($sformatf("err%0d@%0d", d, cyc), {31'd0, err[d]}, {31'd0, e[32]});
`endif
            end
        end
    end

    // Issue one request, update the model, wait (bounded) for ready; return observed data and latency.
    task automatic req(input int d, input bit w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] wd, input bit scramble,
                       output logic [31:0] obs, output int lat);
        int          cap, wc, mk;
        bit          e;
        logic [31:0] cur, rd;
        @(negedge clk);
        ce[d] = 1'b1; we[d] = w; sel[d] = s; addr[d] = a; wdat[d] = wd;
        cap = cyc + 1;
        wc  = (d == 0) ? W0 : W1;
`ifdef DATA_RAM_ERR_EN
        e = (a[31:ADDR_W+2] != 0);
`else
        e = 1'b0;
`endif
        mk = d * 4096 + int'(a[ADDR_W+1:2]);
        rd = 32'd0;
        if (w && !e) begin
            cur = mm.exists(mk) ? mm[mk] : 32'd0;
            for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = wd[8*b +: 8];
            mm[mk] = cur;
        end else if (!w && !e) begin
            rd = mm.exists(mk) ? mm[mk] : 32'd0;
        end
        exp_resp[d * 1000000 + cap + wc] = {e, rd};
        obs = 32'd0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (scramble) begin
                addr[d] = a ^ 32'h4;
                wdat[d] = ~wd;
            end
            if (rdy[d]) begin
                obs = dout[d];
                lat = cyc - cap + 1;
                break;
            end
        end
        if (lat < 0) check($sformatf("timeout%0d", d), 32'd0, 32'd1);
        ce[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] obs;
        int          lat;
        int          cap;

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ce[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'd0; addr[d] = 32'd0; wdat[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        check("rst_ready0", {31'd0, rdy[0]}, 32'd0);
        check("rst_data0", dout[0], 32'd0);
        check("rst_ready1", {31'd0, rdy[1]}, 32'd0);
        check("rst_data1", dout[1], 32'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Full-word write then read, ready three cycles after capture.
        req(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, obs, lat);
        check("t1_wr_lat", 32'(lat), 32'd3);
        req(0, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0, obs, lat);
        check("t1_rd_lat", 32'(lat), 32'd3);
        check("t1_rd_data", obs, 32'hDEADBEEF);
        req(0, 1'b0, 4'b1111, 32'h13, 32'h0, 1'b0, obs, lat);
        check("lowbits_ignored", obs, 32'hDEADBEEF);

        // Byte-lane merge and empty-select write.
        req(0, 1'b1, 4'b1111, 32'h20, 32'h11223344, 1'b0, obs, lat);
        req(0, 1'b1, 4'b0100, 32'h20, 32'h00AA0000, 1'b0, obs, lat);
        req(0, 1'b0, 4'b1111, 32'h20, 32'h0, 1'b0, obs, lat);
        check("t2_lane", obs, 32'h11AA3344);
        req(0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, 1'b0, obs, lat);
        req(0, 1'b0, 4'b1111, 32'h20, 32'h0, 1'b0, obs, lat);
        check("t2_sel0", obs, 32'h11AA3344);

        // Reset during WAIT aborts the write.
        req(0, 1'b1, 4'b1111, 32'h40, 32'h12345678, 1'b0, obs, lat);
        @(negedge clk);
        ce[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'b1111; addr[0] = 32'h40; wdat[0] = 32'hCAFEF00D;
        @(negedge clk);
        check("t4_no_ready_wait", {31'd0, rdy[0]}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("t4_rst_ready", {31'd0, rdy[0]}, 32'd0);
        check("t4_rst_data", dout[0], 32'd0);
        ce[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        req(0, 1'b0, 4'b1111, 32'h40, 32'h0, 1'b0, obs, lat);
        check("t4_old_data", obs, 32'h12345678);

        // Out-of-range address: wraps by default, flagged and suppressed with the error option.
        req(0, 1'b1, 4'b1111, 32'h0, 32'h01020304, 1'b0, obs, lat);
        req(0, 1'b1, 4'b1111, 32'h0010_0000, 32'h5A5A5A5A, 1'b0, obs, lat);
        check("t5_wr_lat", 32'(lat), 32'd3);
        req(0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b0, obs, lat);
`ifdef DATA_RAM_ERR_EN
        check("t5_word0", obs, 32'h01020304);
        req(0, 1'b0, 4'b1111, 32'h0010_0000, 32'h0, 1'b0, obs, lat);
        check("t5_err_rd_data", obs, 32'd0);
`else
        check("t5_word0", obs, 32'h5A5A5A5A);
        req(0, 1'b0, 4'b1111, 32'h1010, 32'h0, 1'b0, obs, lat);
        check("wrap_read", obs, 32'hDEADBEEF);
`endif

        // Inputs changed during WAIT have no effect.
        req(0, 1'b1, 4'b1111, 32'h84, 32'h77777777, 1'b0, obs, lat);
        req(0, 1'b1, 4'b1111, 32'h80, 32'h600DF00D, 1'b1, obs, lat);
        req(0, 1'b0, 4'b1111, 32'h80, 32'h0, 1'b0, obs, lat);
        check("t6_captured", obs, 32'h600DF00D);
        req(0, 1'b0, 4'b1111, 32'h84, 32'h0, 1'b0, obs, lat);
        check("t6_neighbour", obs, 32'h77777777);

        // Zero wait states: ready in the cycle after capture, back-to-back spacing of two.
        req(1, 1'b1, 4'b1111, 32'h8, 32'h0BADCAFE, 1'b0, obs, lat);
        check("t3_wr_lat", 32'(lat), 32'd1);
        @(negedge clk);
        ce[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'b1111; addr[1] = 32'h8; wdat[1] = 32'h0;
        cap = cyc + 1;
        exp_resp[1000000 + cap]     = {1'b0, 32'h0BADCAFE};
        exp_resp[1000000 + cap + 2] = {1'b0, 32'h0BADCAFE};
        @(negedge clk);
        check("t3_ready_n1", {31'd0, rdy[1]}, 32'd1);
        check("t3_data_n1", dout[1], 32'h0BADCAFE);
        @(negedge clk);
        check("t3_ready_n2", {31'd0, rdy[1]}, 32'd0);
        @(negedge clk);
        check("t3_ready_n3", {31'd0, rdy[1]}, 32'd1);
        ce[1] = 1'b0;

        repeat (4) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
